pc_sequencer: RTL

- Parametrised next-generation program-counter and fetch sequencer for the CPU system.
- Replaces the free-running PC+4 register with a multicycle FETCH/EXEC sequencer that handles:
  - a handshaked instruction-memory fetch;
  - branch, jump, SYS_load override and stall;
  - precise exception entry with EPC/cause capture and exception return.
- Sits between the control/ALU datapath (branch/jump/exception requests) and IMEM (address/ready).

---
 rtl/pcseq_pkg.sv | 15 +
 rtl/pc_sequencer_if.sv | 11 +
 rtl/pc_next_calc.sv | 31 +++
 rtl/pc_sequencer.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/pcseq_pkg.sv
// Shared types and constants for the program-counter / fetch sequencer.
package pcseq_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC  = 2'd1,
        TRAP  = 2'd2,
        HALT  = 2'd3
    } pcseq_state_t;

    localparam logic [3:0]  CAUSE_FETCH_TIMEOUT = 4'hF;
    localparam logic [31:0] DEFAULT_RESET_VEC   = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_EXC_VEC     = 32'h0000_0080;

endpackage

// File: rtl/pc_sequencer_if.sv
// Instruction-memory fetch handshake between the sequencer (master) and IMEM (slave).
interface pc_sequencer_if #(
    parameter int PC_W = 32
);
    logic            fetch_req;
    logic [PC_W-1:0] fetch_addr;
    logic            fetch_ready;

    modport master (output fetch_req, output fetch_addr, input fetch_ready);
    modport slave  (input fetch_req, input fetch_addr, output fetch_ready);
endinterface

// File: rtl/pc_next_calc.sv
// Combinational next-PC candidates: sequential, branch and jump targets.
module pc_next_calc #(
    parameter int PC_W  = 32,
    parameter int IMM_W = 16,
    parameter int JT_W  = 26
) (
    input  logic [PC_W-1:0]  pc,
    input  logic [IMM_W-1:0] branch_off,
    input  logic [JT_W-1:0]  jump_target,
    output logic [PC_W-1:0]  pc_plus4,
    output logic [PC_W-1:0]  branch_pc,
    output logic [PC_W-1:0]  jump_pc
);
    logic [PC_W-1:0] off_words;
    logic [JT_W+1:0] jt_bytes;

    assign pc_plus4  = pc + PC_W'(4);
    assign off_words = PC_W'($signed(branch_off));
    assign branch_pc = pc_plus4 + (off_words << 2);
    assign jt_bytes  = {jump_target, 2'b00};

    // The jump keeps the region bits of pc+4 above the target field, if any remain.
    generate
        if (PC_W > JT_W + 2) begin : g_jump_region
            assign jump_pc = {pc_plus4[PC_W-1:JT_W+2], jt_bytes};
        end else begin : g_jump_trunc
            assign jump_pc = jt_bytes[PC_W-1:0];
        end
    endgenerate

endmodule

// File: rtl/pc_sequencer.sv
// FETCH/EXEC program-counter sequencer with exception entry/return and halt on double fault.
// Optional fetch watchdog enabled by defining PCSEQ_FETCH_TIMEOUT_EN.
//
// state | meaning
// FETCH | fetch_req held with fetch_addr=pc until fetch_ready
// EXEC  | instruction executing; next-PC selected by priority
// TRAP  | one flush cycle after exception entry, pc already at EXC_VEC
// HALT  | double fault; only reset or SYS_load leaves
module pc_sequencer
    import pcseq_pkg::*;
#(
    parameter int          PC_W          = 32,
    parameter int          IMM_W         = 16,
    parameter int          JT_W          = 26,
    parameter logic [31:0] RESET_VEC     = DEFAULT_RESET_VEC,
    parameter logic [31:0] EXC_VEC       = DEFAULT_EXC_VEC,
    parameter int          FETCH_TIMEOUT = 15
) (
    input  logic              SYS_clk,
    input  logic              SYS_reset_n,
    input  logic              SYS_load,
    input  logic [PC_W-1:0]   SYS_pc_val,
    input  logic              stall,
    input  logic              branch_taken,
    input  logic [IMM_W-1:0]  branch_off,
    input  logic              jump,
    input  logic [JT_W-1:0]   jump_target,
    input  logic              exc_req,
    input  logic [3:0]        exc_cause,
    input  logic              eret,
    pc_sequencer_if.master    imem,
    output logic              instr_valid,
    output logic [PC_W-1:0]   pc,
    output logic [PC_W-1:0]   pc_plus4,
    output logic [PC_W-1:0]   epc,
    output logic [3:0]        cause,
    output logic              in_exception,
    output logic              halted
);
    localparam logic [PC_W-1:0] RST_PC = PC_W'(RESET_VEC);
    localparam logic [PC_W-1:0] EXC_PC = PC_W'(EXC_VEC);

    if (PC_W < 8 || FETCH_TIMEOUT < 1) begin : g_bad_params
        $error("pc_sequencer: PC_W must be >= 8 and FETCH_TIMEOUT >= 1");
    end

    pcseq_state_t    state, state_n;
    logic [PC_W-1:0] pc_n, epc_n, branch_pc, jump_pc;
    logic [3:0]      cause_n;
    logic            in_exc_n, halted_n, iv_n, freq_q, freq_n;
    logic            accept, timeout_hit;

    pc_next_calc #(.PC_W(PC_W), .IMM_W(IMM_W), .JT_W(JT_W)) u_calc (
        .pc          (pc),
        .branch_off  (branch_off),
        .jump_target (jump_target),
        .pc_plus4    (pc_plus4),
        .branch_pc   (branch_pc),
        .jump_pc     (jump_pc)
    );

    assign imem.fetch_req  = freq_q;
    assign imem.fetch_addr = pc;
    // A ready is only meaningful while our request is actually on the bus.
    assign accept = (state == FETCH) && freq_q && imem.fetch_ready;

`ifdef PCSEQ_FETCH_TIMEOUT_EN
    localparam int TO_W = $clog2(FETCH_TIMEOUT + 1);
    logic [TO_W-1:0] to_cnt;

    assign timeout_hit = (state == FETCH) && !accept && (to_cnt == TO_W'(FETCH_TIMEOUT - 1));

    always_ff @(posedge SYS_clk or negedge SYS_reset_n) begin
        if (!SYS_reset_n)
            to_cnt <= '0;
        else if (state != FETCH || accept || SYS_load || timeout_hit)
            to_cnt <= '0;
        else
            to_cnt <= to_cnt + 1'b1;
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_n  = state;
        pc_n     = pc;
        epc_n    = epc;
        cause_n  = cause;
        in_exc_n = in_exception;
        halted_n = halted;
        iv_n     = 1'b0;
        if (SYS_load) begin
            pc_n    = SYS_pc_val & ~PC_W'(3);
            state_n = FETCH;
            if (state == HALT) begin
                halted_n = 1'b0;
                in_exc_n = 1'b0;
            end
        end else begin
            case (state)
                FETCH: begin
                    if (accept) begin
                        state_n = EXEC;
                        iv_n    = 1'b1;
                    end else if (timeout_hit) begin
                        if (in_exception) begin
                            state_n  = HALT;
                            halted_n = 1'b1;
                        end else begin
                            epc_n    = pc;
                            cause_n  = CAUSE_FETCH_TIMEOUT;
                            in_exc_n = 1'b1;
                            pc_n     = EXC_PC;
                            state_n  = TRAP;
                        end
                    end
                end
                EXEC: begin
                    if (exc_req) begin
                        if (in_exception) begin
                            state_n  = HALT;
                            halted_n = 1'b1;
                        end else begin
                            epc_n    = pc;
                            cause_n  = exc_cause;
                            in_exc_n = 1'b1;
                            pc_n     = EXC_PC;
                            state_n  = TRAP;
                        end
                    end else if (!stall) begin
                        state_n = FETCH;
                        if (eret && in_exception) begin
                            pc_n     = epc;
                            in_exc_n = 1'b0;
                        end else if (eret)
                            pc_n = pc_plus4;
                        else if (jump)
                            pc_n = jump_pc;
                        else if (branch_taken)
                            pc_n = branch_pc;
                        else
                            pc_n = pc_plus4;
                    end
                end
                TRAP:    state_n = FETCH;
                default: state_n = HALT;
            endcase
        end
        // Request is registered so it drops for the cycle following a load or trap.
        freq_n = (state_n == FETCH) && !SYS_load;
    end

    always_ff @(posedge SYS_clk or negedge SYS_reset_n) begin
        if (!SYS_reset_n) begin
            state        <= FETCH;
            pc           <= RST_PC;
            epc          <= '0;
            cause        <= '0;
            in_exception <= 1'b0;
            halted       <= 1'b0;
            instr_valid  <= 1'b0;
            freq_q       <= 1'b0;
        end else begin
            state        <= state_n;
            pc           <= pc_n;
            epc          <= epc_n;
            cause        <= cause_n;
            in_exception <= in_exc_n;
            halted       <= halted_n;
            instr_valid  <= iv_n;
            freq_q       <= freq_n;
        end
    end

endmodule
